// File: rtl/xbar_bank_arb.sv
// Per-bank round-robin request arbiter for the cross-bar core.
// Allocates write-buffer IDs and feeds the bank HTU through a one-entry valid/allowIn output stage.
module xbar_bank_arb #(
    parameter int NUM_CH   = 3,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 128,
    parameter int ENTRY_W  = 3,
    parameter int NUM_WBUF = 8,
    parameter int WBID_W   = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_CH-1:0]               ch_req_valid_i,
    input  logic [2*NUM_CH-1:0]             ch_req_opcode_i,
    input  logic [ADDR_W*NUM_CH-1:0]        ch_req_addr_i,
    input  logic [DATA_W*NUM_CH-1:0]        ch_req_data_i,
    input  logic [ENTRY_W*NUM_CH-1:0]       ch_req_entry_id_i,
    output logic [NUM_CH-1:0]               ch_req_grant_o,
    output logic                            htu_valid_o,
    input  logic                            htu_allowIn_i,
    output logic [1:0]                      htu_ch_id_o,
    output logic [1:0]                      htu_opcode_o,
    output logic [ADDR_W-1:0]               htu_addr_o,
    output logic [DATA_W-1:0]               htu_data_o,
    output logic [ENTRY_W-1:0]              htu_entry_id_o,
    output logic [WBID_W-1:0]               htu_wbuffer_id_o,
    input  logic                            wbuf_release_valid_i,
    input  logic [WBID_W-1:0]               wbuf_release_id_i,
    output logic [$clog2(NUM_WBUF):0]       wbuf_free_cnt_o,
    output logic                            err_o
);

    localparam int         CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int         WIDX_W   = (NUM_WBUF > 1) ? $clog2(NUM_WBUF) : 1;
    localparam int         CNT_W    = $clog2(NUM_WBUF) + 1;
    localparam logic [1:0] OP_WRITE = 2'b01;

    logic [CH_W-1:0]     rr_ptr_r;
    logic [NUM_WBUF-1:0] wbuf_busy_r;
    logic [CNT_W-1:0]    free_cnt_r;
    logic                err_r;

    logic [1:0]          opcode_a [NUM_CH];
    logic [ADDR_W-1:0]   addr_a   [NUM_CH];
    logic [DATA_W-1:0]   data_a   [NUM_CH];
    logic [ENTRY_W-1:0]  entry_a  [NUM_CH];

    logic [NUM_CH-1:0]   eligible_s;
    logic                any_free_s;
    logic                any_eligible_s;
    logic [CH_W-1:0]     winner_s;
    logic                load_s;
    logic                win_is_write_s;
    logic                alloc_s;
    logic                alloc_found_s;
    logic [WIDX_W-1:0]   alloc_idx_s;
    logic [NUM_WBUF-1:0] alloc_mask_s;
    logic [WIDX_W-1:0]   rel_idx_s;
    logic                release_ok_s;
    logic                release_err_s;
    logic [NUM_WBUF-1:0] release_mask_s;
    logic [CH_W-1:0]     rr_next_s;

    // Unpack flat channel buses and compute per-channel eligibility
    always_comb begin
        any_free_s = ~(&wbuf_busy_r);
        for (int i = 0; i < NUM_CH; i++) begin
            opcode_a[i]   = ch_req_opcode_i[2*i +: 2];
            addr_a[i]     = ch_req_addr_i[i*ADDR_W +: ADDR_W];
            data_a[i]     = ch_req_data_i[i*DATA_W +: DATA_W];
            entry_a[i]    = ch_req_entry_id_i[i*ENTRY_W +: ENTRY_W];
            eligible_s[i] = ch_req_valid_i[i] & ((opcode_a[i] != OP_WRITE) | any_free_s);
        end
    end

    // Round-robin search: first eligible channel at or after rr_ptr
    always_comb begin
        winner_s       = '0;
        any_eligible_s = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            int  idx;
            logic hit;
            idx            = int'(rr_ptr_r) + k;
            idx            = (idx >= NUM_CH) ? (idx - NUM_CH) : idx;
            hit            = !any_eligible_s && eligible_s[CH_W'(idx)];
            winner_s       = hit ? CH_W'(idx) : winner_s;
            any_eligible_s = any_eligible_s | hit;
        end
    end

    // Load/grant decision; output stage may refill in the cycle it drains
    always_comb begin
        load_s         = any_eligible_s & (~htu_valid_o | htu_allowIn_i) & ~rst;
        ch_req_grant_o = load_s ? (NUM_CH'(1'b1) << winner_s) : '0;
        win_is_write_s = (opcode_a[winner_s] == OP_WRITE);
        alloc_s        = load_s & win_is_write_s;
        rr_next_s      = (winner_s == CH_W'(NUM_CH - 1)) ? '0 : (winner_s + CH_W'(1'b1));
    end

    // Lowest-index free write buffer
    always_comb begin
        alloc_idx_s   = '0;
        alloc_found_s = 1'b0;
        for (int j = 0; j < NUM_WBUF; j++) begin
            logic hit;
            hit           = !alloc_found_s && !wbuf_busy_r[j];
            alloc_idx_s   = hit ? WIDX_W'(j) : alloc_idx_s;
            alloc_found_s = alloc_found_s | hit;
        end
        alloc_mask_s = alloc_s ? (NUM_WBUF'(1'b1) << alloc_idx_s) : '0;
    end

    // Release check: only a busy, in-range ID may be freed; anything else is a protocol error
    always_comb begin
        rel_idx_s      = wbuf_release_id_i[WIDX_W-1:0];
        release_ok_s   = wbuf_release_valid_i
                         & (int'(wbuf_release_id_i) < NUM_WBUF)
                         & wbuf_busy_r[rel_idx_s];
        release_err_s  = wbuf_release_valid_i & ~release_ok_s;
        release_mask_s = release_ok_s ? (NUM_WBUF'(1'b1) << rel_idx_s) : '0;
    end

    // Arbiter pointer, write-buffer pool and sticky error state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_r    <= '0;
            wbuf_busy_r <= '0;
            free_cnt_r  <= CNT_W'(NUM_WBUF);
            err_r       <= 1'b0;
        end else begin
            if (load_s) begin
                rr_ptr_r <= rr_next_s;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
            wbuf_busy_r <= (wbuf_busy_r | alloc_mask_s) & ~release_mask_s;
            free_cnt_r  <= free_cnt_r + CNT_W'(release_ok_s) - CNT_W'(alloc_s);
            err_r       <= err_r | release_err_s;
        end
    end

    // One-entry HTU output stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            htu_valid_o      <= 1'b0;
            htu_ch_id_o      <= '0;
            htu_opcode_o     <= '0;
            htu_addr_o       <= '0;
            htu_data_o       <= '0;
            htu_entry_id_o   <= '0;
            htu_wbuffer_id_o <= '0;
        end else if (load_s) begin
            htu_valid_o      <= 1'b1;
            htu_ch_id_o      <= 2'(winner_s);
            htu_opcode_o     <= opcode_a[winner_s];
            htu_addr_o       <= {addr_a[winner_s][ADDR_W-1:4], 4'b0000};
            htu_data_o       <= data_a[winner_s];
            htu_entry_id_o   <= entry_a[winner_s];
            htu_wbuffer_id_o <= win_is_write_s ? WBID_W'(alloc_idx_s) : '0;
        end else if (htu_allowIn_i) begin
            htu_valid_o      <= 1'b0;
        end else begin
            htu_valid_o      <= htu_valid_o;
        end
    end

    assign wbuf_free_cnt_o = free_cnt_r;
    assign err_o           = err_r;

endmodule
